johnson_phase_decoder: RTL

- Downstream consumer of the 5-bit Johnson counter. Samples the counter's q bus each clock.
- Produces a registered one-hot phase vector and a binary phase index.
- Flags illegal (non-Johnson) codes and illegal transitions between consecutive samples.
- Counts completed 10-state revolutions. Feeds phase-sequenced control logic and the on-chip health monitor.

---
 rtl/johnson_phase_decoder.sv | 88 ++++++++
 1 files changed

// File: rtl/johnson_phase_decoder.sv
// Decodes a sampled Johnson counter bus into a registered phase (one-hot and binary),
// flags illegal codes and out-of-order transitions, and counts full revolutions.
module johnson_phase_decoder #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [WIDTH-1:0]                q_in,
  input  logic                            clr_err,
  output logic [2*WIDTH-1:0]              phase_onehot,
  output logic [$clog2(2*WIDTH)-1:0]      phase_idx,
  output logic                            phase_valid,
  output logic                            step,
  output logic                            illegal_state,
  output logic                            seq_error,
  output logic                            cycle_wrap,
  output logic [CNT_W-1:0]                cycle_count
);

  localparam int N     = 2 * WIDTH;
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  // Phase k < =WIDTH fills k ones from the LSB; later phases keep N-k ones at the top.
  function automatic logic [WIDTH-1:0] phase_code(input int k);
    int m;
    if (k <= WIDTH) begin
      phase_code = WIDTH'((1 << k) - 1);
    end else begin
      m = N - k;
      phase_code = WIDTH'(((1 << m) - 1) << (WIDTH - m));
    end
  endfunction

  logic             dec_vld_p0;
  logic [IDX_W-1:0] dec_idx_p0;
  logic [IDX_W-1:0] next_idx_p0;
  logic             chk_p0;
  logic             step_p0;
  logic             wrap_p0;
  logic             seq_err_p0;

  // Stage p0: decode the raw sample and compare it against the last registered phase.
  always_comb begin
    dec_vld_p0 = 1'b0;
    dec_idx_p0 = '0;
    for (int k = 0; k < N; k++) begin
      if (q_in == phase_code(k)) begin
        dec_vld_p0 = 1'b1;
        dec_idx_p0 = IDX_W'(k);
      end
    end
  end

  // phase_idx/phase_valid double as the previous-sample reference.
  always_comb begin
    next_idx_p0 = (phase_idx == LAST_IDX) ? '0 : phase_idx + IDX_W'(1);
    chk_p0      = phase_valid && dec_vld_p0;
    step_p0     = chk_p0 && (dec_idx_p0 == next_idx_p0);
    wrap_p0     = step_p0 && (phase_idx == LAST_IDX);
    seq_err_p0  = chk_p0 && (dec_idx_p0 != phase_idx) && !step_p0;
  end

  // Stage p1: registered outputs and sticky flags (a new error beats clr_err).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_onehot  <= '0;
      phase_idx     <= '0;
      phase_valid   <= 1'b0;
      step          <= 1'b0;
      illegal_state <= 1'b0;
      seq_error     <= 1'b0;
      cycle_wrap    <= 1'b0;
      cycle_count   <= '0;
    end else begin
      phase_valid   <= dec_vld_p0;
      phase_idx     <= dec_vld_p0 ? dec_idx_p0 : '0;
      phase_onehot  <= dec_vld_p0 ? ({{(N-1){1'b0}}, 1'b1} << dec_idx_p0) : '0;
      step          <= step_p0;
      cycle_wrap    <= wrap_p0;
      cycle_count   <= cycle_count + CNT_W'(wrap_p0);
      illegal_state <= !dec_vld_p0 || (illegal_state && !clr_err);
      seq_error     <= seq_err_p0 || (seq_error && !clr_err);
    end
  end

endmodule
